// File: rtl/sweep_pkg.sv
// Shared widths, FSM encoding and sweep bundle
// for the sweep recorder and its register file.
package sweep_pkg;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam logic [IDX_W-1:0] CNT_MAX = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    SEEN1,
    UP,
    DOWN,
    REPORT
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  first;
    logic [IDX_W-1:0]  last;
    logic              dir;
    logic              err;
    logic [DATA_W-1:0] cks;
  } sweep_t;

endpackage

// File: rtl/regfile32.sv
// 32x32 register file, one write port, one
// combinational read port, register 0 reads as 0.
module regfile32
  import sweep_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q;
  logic [NREGS-1:0][DATA_W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (waddr != '0) begin
      mem_d[waddr] = wdata;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = (raddr == '0) ? '0 : mem_q[raddr];

endmodule

// File: rtl/sweep_recorder.sv
// Records register-index sweeps from an upstream
// sequencer and emits a one-cycle report on done.
module sweep_recorder
  import sweep_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  regnum,
  input  logic [DATA_W-1:0] wdata,
  input  logic              done,
  input  logic [IDX_W-1:0]  rsel,
  output logic [DATA_W-1:0] rdata,
  output logic              sweep_valid,
  output logic [IDX_W-1:0]  sweep_count,
  output logic [IDX_W-1:0]  sweep_first,
  output logic [IDX_W-1:0]  sweep_last,
  output logic              sweep_dir,
  output logic              sweep_err,
  output logic [DATA_W-1:0] checksum
);

  state_e state_q, state_d;
  sweep_t sw_q, sw_d;
  sweep_t rpt_q, rpt_d;
  logic   done_prev_q, done_prev_d;
  logic   rise;
  logic   is_new;
  logic   step_up;
  logic   step_dn;

  regfile32 u_rf (
    .clock (clock),
    .reset (reset),
    .waddr (regnum),
    .wdata (wdata),
    .raddr (rsel),
    .rdata (rdata)
  );

  assign rise    = done && !done_prev_q;
  assign is_new  = (regnum != '0) &&
                   (regnum != sw_q.last);
  assign step_up = (regnum == sw_q.last + 5'd1);
  assign step_dn = (regnum == sw_q.last - 5'd1);

  always_comb begin
    state_d     = state_q;
    sw_d        = sw_q;
    rpt_d       = rpt_q;
    done_prev_d = done;
    if (is_new && state_q != IDLE &&
        state_q != REPORT) begin
      sw_d.last = regnum;
      sw_d.cks  = sw_q.cks ^ wdata;
      if (sw_q.count != CNT_MAX) begin
        sw_d.count = sw_q.count + 5'd1;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (regnum != '0) begin
          state_d    = SEEN1;
          sw_d.count = 5'd1;
          sw_d.first = regnum;
          sw_d.last  = regnum;
          sw_d.dir   = 1'b0;
          sw_d.err   = 1'b0;
          sw_d.cks   = wdata;
        end
      end
      SEEN1: begin
        if (is_new) begin
          if (step_up) begin
            state_d  = UP;
            sw_d.dir = 1'b1;
          end else if (step_dn) begin
            state_d = DOWN;
          end else begin
            sw_d.err = 1'b1;
          end
        end
      end
      UP: begin
        if (is_new && !step_up) begin
          sw_d.err = 1'b1;
        end
      end
      DOWN: begin
        if (is_new && !step_dn) begin
          sw_d.err = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        sw_d    = '0;
      end
      default: begin
        state_d = IDLE;
        sw_d    = '0;
      end
    endcase
    // A coincident write is already folded into sw_d here.
    if (rise && state_q != REPORT) begin
      state_d = REPORT;
      rpt_d   = sw_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sw_q        <= '0;
      rpt_q       <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_q        <= sw_d;
      rpt_q       <= rpt_d;
      done_prev_q <= done_prev_d;
    end
  end

  assign sweep_valid = (state_q == REPORT);
  assign sweep_count = rpt_q.count;
  assign sweep_first = rpt_q.first;
  assign sweep_last  = rpt_q.last;
  assign sweep_dir   = rpt_q.dir;
  assign sweep_err   = rpt_q.err;
  assign checksum    = rpt_q.cks;

endmodule

// File: tb/tb_sweep_recorder.sv
// Directed self-checking bench for sweep_recorder.
module tb_sweep_recorder;

  logic        clock;
  logic        reset;
  logic [4:0]  regnum;
  logic [31:0] wdata;
  logic        done;
  logic [4:0]  rsel;
  logic [31:0] rdata;
  logic        sweep_valid;
  logic [4:0]  sweep_count;
  logic [4:0]  sweep_first;
  logic [4:0]  sweep_last;
  logic        sweep_dir;
  logic        sweep_err;
  logic [31:0] checksum;

  int n_chk;
  int n_fail;
  int pulses;

  sweep_recorder dut (
    .clock       (clock),
    .reset       (reset),
    .regnum      (regnum),
    .wdata       (wdata),
    .done        (done),
    .rsel        (rsel),
    .rdata       (rdata),
    .sweep_valid (sweep_valid),
    .sweep_count (sweep_count),
    .sweep_first (sweep_first),
    .sweep_last  (sweep_last),
    .sweep_dir   (sweep_dir),
    .sweep_err   (sweep_err),
    .checksum    (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] r,
                    input logic [31:0] d);
    regnum = r;
    wdata  = d;
    tick();
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] r,
                    input logic [31:0] exp);
    rsel = r;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    regnum = '0;
    wdata  = '0;
    done   = 1'b0;
    rsel   = '0;
    #2;
    chk("rst_valid", {31'd0, sweep_valid}, 32'd0);
    chk("rst_count", {27'd0, sweep_count}, 32'd0);
    chk("rst_cks", checksum, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Ascending sweep with a repeated first write
    wr(5'd8,  32'h0000_0011);
    wr(5'd8,  32'hFFFF_0000);
    wr(5'd9,  32'h0000_0022);
    wr(5'd10, 32'h0000_0044);
    wr(5'd11, 32'h0000_0088);
    wr(5'd12, 32'h0000_0100);
    chk("up_novalid", {31'd0, sweep_valid}, 32'd0);
    regnum = '0;
    done   = 1'b1;
    tick();
    chk("up_valid", {31'd0, sweep_valid}, 32'd1);
    chk("up_count", {27'd0, sweep_count}, 32'd5);
    chk("up_first", {27'd0, sweep_first}, 32'd8);
    chk("up_last", {27'd0, sweep_last}, 32'd12);
    chk("up_dir", {31'd0, sweep_dir}, 32'd1);
    chk("up_err", {31'd0, sweep_err}, 32'd0);
    chk("up_cks", checksum, 32'h0000_01FF);
    tick();
    chk("up_pulse1", {31'd0, sweep_valid}, 32'd0);
    chk("up_hold", {27'd0, sweep_count}, 32'd5);
    rd("up_rd8", 5'd8, 32'hFFFF_0000);
    done = 1'b0;
    tick();

    // Descending sweep, done held for 10 cycles
    wr(5'd8, 32'h80);
    wr(5'd7, 32'h70);
    wr(5'd6, 32'h60);
    wr(5'd5, 32'h50);
    wr(5'd4, 32'h40);
    regnum = '0;
    done   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sweep_valid) begin
        pulses++;
        chk("dn_count", {27'd0, sweep_count}, 32'd5);
        chk("dn_first", {27'd0, sweep_first}, 32'd8);
        chk("dn_last", {27'd0, sweep_last}, 32'd4);
        chk("dn_dir", {31'd0, sweep_dir}, 32'd0);
        chk("dn_err", {31'd0, sweep_err}, 32'd0);
        chk("dn_cks", checksum, 32'h80);
      end
    end
    chk("dn_pulses", pulses, 32'd1);
    rd("dn_rd6", 5'd6, 32'h60);
    done = 1'b0;
    tick();

    // Non-adjacent step
    wr(5'd8,  32'h1);
    wr(5'd9,  32'h2);
    wr(5'd11, 32'h4);
    regnum = '0;
    done   = 1'b1;
    tick();
    chk("gap_valid", {31'd0, sweep_valid}, 32'd1);
    chk("gap_err", {31'd0, sweep_err}, 32'd1);
    chk("gap_count", {27'd0, sweep_count}, 32'd3);
    chk("gap_last", {27'd0, sweep_last}, 32'd11);
    chk("gap_cks", checksum, 32'h7);
    done = 1'b0;
    tick();

    // Write coincident with done rising edge
    wr(5'd11, 32'h0000_0011);
    regnum = 5'd12;
    wdata  = 32'hCAFE_F00D;
    done   = 1'b1;
    tick();
    chk("co_valid", {31'd0, sweep_valid}, 32'd1);
    chk("co_count", {27'd0, sweep_count}, 32'd2);
    chk("co_last", {27'd0, sweep_last}, 32'd12);
    chk("co_dir", {31'd0, sweep_dir}, 32'd1);
    chk("co_cks", checksum, 32'hCAFE_F01C);
    // Write during REPORT: stored, not counted
    wr(5'd5, 32'h55);
    regnum = '0;
    done   = 1'b0;
    tick();
    rd("co_rd12", 5'd12, 32'hCAFE_F00D);
    rd("rep_rd5", 5'd5, 32'h55);
    done = 1'b1;
    tick();
    chk("idle_valid", {31'd0, sweep_valid}, 32'd1);
    chk("idle_count", {27'd0, sweep_count}, 32'd0);
    chk("idle_first", {27'd0, sweep_first}, 32'd0);
    chk("idle_cks", checksum, 32'd0);
    done = 1'b0;
    tick();

    // regnum 0 write is ignored
    wr(5'd3, 32'h33);
    wr(5'd0, 32'hFFFF_FFFF);
    rd("z_rd0", 5'd0, 32'd0);
    regnum = '0;
    wdata  = '0;
    done   = 1'b1;
    tick();
    chk("z_valid", {31'd0, sweep_valid}, 32'd1);
    chk("z_count", {27'd0, sweep_count}, 32'd1);
    chk("z_cks", checksum, 32'h33);
    done = 1'b0;
    tick();

    // Reset mid-sweep
    wr(5'd8, 32'hAAAA_0008);
    chk("rs_nov1", {31'd0, sweep_valid}, 32'd0);
    wr(5'd9, 32'hAAAA_0009);
    chk("rs_nov2", {31'd0, sweep_valid}, 32'd0);
    regnum = '0;
    #2;
    reset = 1'b0;
    #1;
    chk("rs_async_cnt", {27'd0, sweep_count}, 32'd0);
    rd("rs_async_rd", 5'd8, 32'd0);
    tick();
    chk("rs_nov3", {31'd0, sweep_valid}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rs_nov4", {31'd0, sweep_valid}, 32'd0);
    done = 1'b1;
    tick();
    chk("rs_valid", {31'd0, sweep_valid}, 32'd1);
    chk("rs_count", {27'd0, sweep_count}, 32'd0);
    chk("rs_last", {27'd0, sweep_last}, 32'd0);
    chk("rs_cks", checksum, 32'd0);
    for (int r = 0; r < 32; r++) begin
      rd("rs_rd", 5'(r), 32'd0);
    end
    done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
